// File: rtl/aes_round_ctrl.sv
// AES-128 encryption round sequencer.
// Drives the load/select/bypass strobes for the state register and the round logic,
// paces the registered SubBytes stage, and handshakes with the key source and the
// block's input/output streams. No 128-bit data passes through this block.
module aes_round_ctrl #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned SB_LATENCY = 1,
    parameter int unsigned RW         = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          key_req,
    input  logic          key_ack,
    output logic [RW-1:0] round_o,
    output logic          sb_en,
    output logic          state_ld,
    output logic          sel_init,
    output logic          mc_bypass,
    output logic          busy
);

    // SubBytes wait counter only needs to reach SB_LATENCY-1
    localparam int unsigned CW = (SB_LATENCY > 1) ? $clog2(SB_LATENCY) : 1;

    localparam logic [RW-1:0] LastRound = RW'(NUM_ROUNDS);
    localparam logic [CW-1:0] SbLast    = CW'(SB_LATENCY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSub,
        StRnd,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // State, round index and SubBytes counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            round_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and strobe decode; abort overrides everything at the end
    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        key_req   = 1'b0;
        sb_en     = 1'b0;
        state_ld  = 1'b0;
        sel_init  = 1'b0;
        mc_bypass = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = StLoad;
                    round_d = '0;
                end
            end
            StLoad: begin
                key_req  = 1'b1;
                sel_init = 1'b1;
                state_ld = key_ack;
                if (key_ack) begin
                    state_d = StSub;
                    round_d = RW'(1);
                end
            end
            StSub: begin
                sb_en = 1'b1;
                if (cnt_q == SbLast) begin
                    state_d = StRnd;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StRnd: begin
                // SubBytes is not re-enabled while waiting for the key, so its output holds
                key_req   = 1'b1;
                mc_bypass = (round_q == LastRound);
                state_ld  = key_ack;
                if (key_ack) begin
                    if (round_q == LastRound) begin
                        state_d = StDone;
                    end else begin
                        state_d = StSub;
                        round_d = round_q + RW'(1);
                    end
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                round_d = '0;
                cnt_d   = '0;
            end
        endcase

        if (abort) begin
            state_d  = StIdle;
            round_d  = '0;
            cnt_d    = '0;
            state_ld = 1'b0;
            sb_en    = 1'b0;
            key_req  = 1'b0;
        end
    end

    assign round_o = round_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: directed scenarios with a behavioural AES datapath
// driven by the controller's strobes, checked against the FIPS-197 C.1 vector.
module tb_aes_round_ctrl;

    localparam int NR = 10;

    logic       clk;
    logic       rst_n;
    logic       abort, in_valid, in_ready, out_valid, out_ready, key_req, key_ack;
    logic [3:0] round_o;
    logic       sb_en, state_ld, sel_init, mc_bypass, busy;

    logic       in_valid3, in_ready3, out_valid3, out_ready3, key_req3, key_ack3;
    logic [3:0] round3;
    logic       sb_en3, state_ld3, sel_init3, mc_bypass3, busy3;

    int n_checks = 0;
    int n_fail   = 0;

    aes_round_ctrl #(.NUM_ROUNDS(NR), .SB_LATENCY(1), .RW(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .key_req(key_req), .key_ack(key_ack),
        .round_o(round_o), .sb_en(sb_en), .state_ld(state_ld), .sel_init(sel_init),
        .mc_bypass(mc_bypass), .busy(busy)
    );

    aes_round_ctrl #(.NUM_ROUNDS(NR), .SB_LATENCY(3), .RW(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .abort(1'b0), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_ready(out_ready3), .key_req(key_req3), .key_ack(key_ack3),
        .round_o(round3), .sb_en(sb_en3), .state_ld(state_ld3), .sel_init(sel_init3),
        .mc_bypass(mc_bypass3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural AES-128 datapath ----------------
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] EXP_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic [7:0]   sbox_t [256];
    logic [127:0] rk [16];
    logic [127:0] dp_st, dp_sb, dp_st_nx, dp_sb_nx;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox_t[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    task automatic build_tables();
        logic [7:0]  inv, r1, r2, r3, r4;
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
            sbox_t[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
        end
        for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[r] = '0;
        for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Strobes are stable at the falling edge; the datapath registers update on the rising edge
    always @(negedge clk) begin
        dp_sb_nx = dp_sb;
        dp_st_nx = dp_st;
        if (sb_en === 1'b1) dp_sb_nx = sub_bytes(dp_st);
        if (state_ld === 1'b1) begin
            if (sel_init) dp_st_nx = PT ^ rk[0];
            else if (mc_bypass) dp_st_nx = shift_rows(dp_sb) ^ rk[round_o];
            else dp_st_nx = mix_columns(shift_rows(dp_sb)) ^ rk[round_o];
        end
    end

    always @(posedge clk) begin
        dp_sb <= dp_sb_nx;
        dp_st <= dp_st_nx;
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input int stall_round, input int stall_n, output int lat,
                             output int rnd_ld, output int byp_n, output int byp_bad,
                             output int stall_seen, output int stall_bad);
        int left = stall_n;
        lat = 0; rnd_ld = 0; byp_n = 0; byp_bad = 0; stall_seen = 0; stall_bad = 0;
        in_valid = 1'b1;
        key_ack  = 1'b1;
        step();
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && lat < 200) begin
            key_ack = 1'b1;
            if (key_req && !sel_init && int'(round_o) == stall_round && left > 0) begin
                key_ack = 1'b0;
                left--;
                stall_seen++;
            end
            #1;
            if (!key_ack && (sb_en !== 1'b0 || state_ld !== 1'b0 || int'(round_o) != stall_round))
                stall_bad++;
            if (state_ld === 1'b1 && !sel_init) rnd_ld++;
            if (mc_bypass === 1'b1) begin
                byp_n++;
                if (int'(round_o) != NR) byp_bad++;
            end
            step();
            lat++;
        end
    endtask

    task automatic finish_block();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [11:0] obs, obs3;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        obs  = {in_ready, out_valid, key_req, sb_en, state_ld, sel_init, mc_bypass, busy, round_o};
        obs3 = {in_ready3, out_valid3, key_req3, sb_en3, state_ld3, sel_init3, mc_bypass3, busy3,
                round3};
        n_checks++;
        if (obs !== 12'h800) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 800", obs);
        end
        n_checks++;
        if (obs3 !== 12'h800) begin
            n_fail++;
            $display("FAIL reset_outputs_sb3: got %h expected 800", obs3);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_release: in_ready=%b busy=%b expected 1/0", in_ready, busy);
        end
    endtask

    task automatic test_nominal();
        int lat, rnd_ld, byp_n, byp_bad, ss, sb;
        run_block(0, 0, lat, rnd_ld, byp_n, byp_bad, ss, sb);
        n_checks++;
        if (lat != 21) begin
            n_fail++;
            $display("FAIL nominal_latency: got %0d expected 21", lat);
        end
        n_checks++;
        if (rnd_ld != NR) begin
            n_fail++;
            $display("FAIL nominal_round_loads: got %0d expected %0d", rnd_ld, NR);
        end
        n_checks++;
        if (byp_n != 1 || byp_bad != 0) begin
            n_fail++;
            $display("FAIL nominal_bypass: count=%0d off_round=%0d expected 1/0", byp_n, byp_bad);
        end
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL nominal_done_flags: in_ready=%b busy=%b expected 0/1", in_ready, busy);
        end
        n_checks++;
        if (dp_st !== EXP_CT) begin
            n_fail++;
            $display("FAIL nominal_ciphertext: got %h expected %h", dp_st, EXP_CT);
        end
        finish_block();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_return_idle: in_ready=%b out_valid=%b expected 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_key_stall();
        int lat, rnd_ld, byp_n, byp_bad, ss, sb;
        run_block(3, 4, lat, rnd_ld, byp_n, byp_bad, ss, sb);
        n_checks++;
        if (lat != 25) begin
            n_fail++;
            $display("FAIL stall_latency: got %0d expected 25", lat);
        end
        n_checks++;
        if (ss != 4 || sb != 0) begin
            n_fail++;
            $display("FAIL stall_hold: stalls=%0d bad_cycles=%0d expected 4/0", ss, sb);
        end
        n_checks++;
        if (dp_st !== EXP_CT) begin
            n_fail++;
            $display("FAIL stall_ciphertext: got %h expected %h", dp_st, EXP_CT);
        end
        finish_block();
    endtask

    task automatic test_out_backpressure();
        int lat, rnd_ld, byp_n, byp_bad, ss, sb;
        int bad = 0;
        run_block(0, 0, lat, rnd_ld, byp_n, byp_bad, ss, sb);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
            step();
        end
        n_checks++;
        if (bad != 0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL done_hold: bad_cycles=%0d busy=%b expected 0/1", bad, busy);
        end
        finish_block();
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL no_accept_from_done: in_ready=%b busy=%b expected 1/0",
                     in_ready, busy);
        end
        step();
        n_checks++;
        if (busy !== 1'b1 || key_req !== 1'b1 || round_o !== 4'd0) begin
            n_fail++;
            $display("FAIL accept_after_idle: busy=%b key_req=%b round=%0d expected 1/1/0",
                     busy, key_req, round_o);
        end
        in_valid = 1'b0;
        abort    = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_abort();
        int n = 0;
        int lds = 0;
        int lat, rnd_ld, byp_n, byp_bad, ss, sb;
        in_valid = 1'b1;
        key_ack  = 1'b1;
        step();
        in_valid = 1'b0;
        while (!(round_o == 4'd5 && sb_en === 1'b1) && n < 100) begin
            step();
            n++;
        end
        n_checks++;
        if (round_o !== 4'd5 || sb_en !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reach_r5: round=%0d sb_en=%b expected 5/1", round_o, sb_en);
        end
        abort = 1'b1;
        #1;
        n_checks++;
        if (sb_en !== 1'b0 || key_req !== 1'b0 || state_ld !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_strobes: sb_en=%b key_req=%b state_ld=%b expected 0/0/0",
                     sb_en, key_req, state_ld);
        end
        step();
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || round_o !== 4'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_to_idle: busy=%b round=%0d in_ready=%b expected 0/0/1",
                     busy, round_o, in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            if (state_ld !== 1'b0) lds++;
            step();
        end
        n_checks++;
        if (lds != 0) begin
            n_fail++;
            $display("FAIL abort_no_loads: got %0d loads expected 0", lds);
        end
        in_valid = 1'b1;
        abort    = 1'b1;
        step();
        in_valid = 1'b0;
        abort    = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_blocks_accept: busy=%b expected 0", busy);
        end
        run_block(0, 0, lat, rnd_ld, byp_n, byp_bad, ss, sb);
        n_checks++;
        if (lat != 21 || dp_st !== EXP_CT) begin
            n_fail++;
            $display("FAIL abort_fresh_block: latency=%0d ct=%h expected 21/%h", lat, dp_st,
                     EXP_CT);
        end
        finish_block();
    endtask

    task automatic test_sb_latency3();
        int lat = 0;
        int run = 0;
        int runs = 0;
        int bad = 0;
        in_valid3 = 1'b1;
        key_ack3  = 1'b1;
        step();
        in_valid3 = 1'b0;
        while (out_valid3 !== 1'b1 && lat < 200) begin
            if (sb_en3 === 1'b1) run++;
            else if (run != 0) begin
                runs++;
                if (run != 3) bad++;
                run = 0;
            end
            step();
            lat++;
        end
        n_checks++;
        if (lat != 41) begin
            n_fail++;
            $display("FAIL sb3_latency: got %0d expected 41", lat);
        end
        n_checks++;
        if (runs != NR || bad != 0) begin
            n_fail++;
            $display("FAIL sb3_sub_runs: runs=%0d bad=%0d expected %0d/0", runs, bad, NR);
        end
        out_ready3 = 1'b1;
        step();
        out_ready3 = 1'b0;
        n_checks++;
        if (busy3 !== 1'b0) begin
            n_fail++;
            $display("FAIL sb3_return_idle: busy=%b expected 0", busy3);
        end
    endtask

    task automatic test_reset_midround();
        int n = 0;
        logic [11:0] obs;
        int lat, rnd_ld, byp_n, byp_bad, ss, sb;
        in_valid = 1'b1;
        key_ack  = 1'b1;
        step();
        in_valid = 1'b0;
        while (round_o != 4'd7 && n < 100) begin
            step();
            n++;
        end
        rst_n = 1'b0;
        #1;
        obs = {in_ready, out_valid, key_req, sb_en, state_ld, sel_init, mc_bypass, busy, round_o};
        n_checks++;
        if (obs !== 12'h800) begin
            n_fail++;
            $display("FAIL async_reset_midround: got %h expected 800", obs);
        end
        step();
        rst_n = 1'b1;
        step();
        obs = {in_ready, out_valid, key_req, sb_en, state_ld, sel_init, mc_bypass, busy, round_o};
        n_checks++;
        if (obs !== 12'h800) begin
            n_fail++;
            $display("FAIL after_release: got %h expected 800", obs);
        end
        run_block(0, 0, lat, rnd_ld, byp_n, byp_bad, ss, sb);
        n_checks++;
        if (lat != 21 || dp_st !== EXP_CT) begin
            n_fail++;
            $display("FAIL post_reset_vector: latency=%0d ct=%h expected 21/%h", lat, dp_st,
                     EXP_CT);
        end
        finish_block();
    endtask

    initial begin
        abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0; key_ack = 1'b0;
        in_valid3 = 1'b0; out_ready3 = 1'b0; key_ack3 = 1'b0;
        dp_st = '0; dp_sb = '0;
        build_tables();
        test_reset();
        test_nominal();
        test_key_stall();
        test_out_backpressure();
        test_abort();
        test_sb_latency3();
        test_reset_midround();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
